// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register indices with speculative/committed heads and flush recovery
module free_list #(
    parameter int NUM_PREGS           = 64,
    parameter int PHYS_REGS_ADDR_SIZE = 6,
    parameter int ARCH_REGS           = 32,
    parameter int FRONTEND_WIDTH      = 2,
    parameter int COMMIT_WIDTH        = 2
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [FRONTEND_WIDTH-1:0]                           rename_req_i,
    output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0]  freelist_preg_o,
    output logic                                                freelist_ready_o,
    input  logic [COMMIT_WIDTH-1:0]                             commit_rd_v_i,
    input  logic [COMMIT_WIDTH-1:0]                             commit_free_v_i,
    input  logic [COMMIT_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0]    commit_free_preg_i,
    input  logic                                                flush_i,
    output logic [PHYS_REGS_ADDR_SIZE:0]                        free_count_o,
    output logic                                                overflow_err_o
);
    localparam int AW = PHYS_REGS_ADDR_SIZE;
    localparam int PW = AW + 1;
    logic [AW-1:0] entry [NUM_PREGS];
    logic [PW-1:0] alloc_ptr, commit_ptr, free_ptr;
    logic [PW-1:0] n_alloc, n_commit, n_free, occ, in_flight;
    logic [COMMIT_WIDTH-1:0] wr_en;
    logic [COMMIT_WIDTH-1:0][AW-1:0] wr_idx;
    logic drop, commit_err;
    assign free_count_o     = free_ptr - alloc_ptr;
    assign freelist_ready_o = free_count_o >= PW'(FRONTEND_WIDTH);
    assign occ              = free_ptr - commit_ptr;
    assign in_flight        = alloc_ptr - commit_ptr;
    assign commit_err       = n_commit > in_flight;
    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < FRONTEND_WIDTH; i++) begin
            freelist_preg_o[i] = entry[AW'(alloc_ptr + n_alloc)];
            n_alloc = n_alloc + PW'(rename_req_i[i]);
        end
    end
    always_comb begin
        n_commit = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++)
            n_commit = n_commit + PW'(commit_rd_v_i[j]);
        n_free = '0;
        drop   = 1'b0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            wr_en[j]  = 1'b0;
            wr_idx[j] = AW'(free_ptr + n_free);
            if (commit_free_v_i[j] && commit_free_preg_i[j] != '0) begin
                if (occ + n_free < PW'(NUM_PREGS)) begin
                    wr_en[j] = 1'b1;
                    n_free   = n_free + PW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_PREGS; k++)
                entry[k] <= (k < NUM_PREGS - ARCH_REGS) ? AW'(ARCH_REGS + k) : '0;
            alloc_ptr      <= '0;
            commit_ptr     <= '0;
            free_ptr       <= PW'(NUM_PREGS - ARCH_REGS);
            overflow_err_o <= 1'b0;
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++)
                if (wr_en[j]) entry[wr_idx[j]] <= commit_free_preg_i[j];
            alloc_ptr  <= flush_i ? commit_ptr + n_commit
                        : freelist_ready_o ? alloc_ptr + n_alloc : alloc_ptr;
            commit_ptr <= commit_ptr + n_commit;
            free_ptr   <= free_ptr + n_free;
            if (drop || commit_err) overflow_err_o <= 1'b1;
        end
    end
endmodule
